// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver front end feeding the RX FIFO write port.
// Synchronises the serial line and finds the start bit on a falling edge. It then
// samples each bit at mid-bit using a runtime baud divisor, and reports good
// bytes, framing errors and overruns as single-cycle pulses.
module uart_rx_core #(
   parameter int SYNC_STAGES = 2,
   parameter int DIV_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rx_en_i,
   input  logic [DIV_W-1:0] clks_per_bit_i,
   input  logic             rx_i,
   input  logic             full_i,
   output logic [7:0]       data_o,
   output logic             wr_en_o,
   output logic             frame_err_o,
   output logic             overrun_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_sync;
   logic                   prev_q;
   logic [DIV_W-1:0]       cnt_q;
   logic [DIV_W-1:0]       n_q;
   logic [DIV_W-1:0]       n_clamped;
   logic [DIV_W-1:0]       half_m1;
   logic [DIV_W-1:0]       full_m1;
   logic [2:0]             bit_idx_q;
   logic [7:0]             shift_q;

   assign rx_sync   = sync_q[SYNC_STAGES-1];
   assign n_clamped = (clks_per_bit_i < DIV_W'(4)) ? DIV_W'(4) : clks_per_bit_i;
   assign half_m1   = (n_q >> 1) - DIV_W'(1);
   assign full_m1   = n_q - DIV_W'(1);

   // Synchronise the asynchronous line and keep a one-cycle-old copy for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
         prev_q <= rx_sync;
      end
   end

   // Frame FSM: start detect, mid-bit sampling, stop-bit decision and registered pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         n_q         <= DIV_W'(4);
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_o      <= '0;
         wr_en_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         wr_en_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         if ((state_q != IDLE) && !rx_en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rx_en_i && prev_q && !rx_sync) begin
                     state_q <= START;
                     cnt_q   <= '0;
                     n_q     <= n_clamped;
                     busy_o  <= 1'b1;
                  end
               end
               START: begin
                  if (cnt_q == half_m1) begin
                     cnt_q <= '0;
                     if (!rx_sync) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                     end else begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + DIV_W'(1);
                  end
               end
               DATA: begin
                  if (cnt_q == full_m1) begin
                     shift_q[bit_idx_q] <= rx_sync;
                     cnt_q              <= '0;
                     if (bit_idx_q == 3'd7) begin
                        state_q <= STOP;
                     end else begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                     end
                  end else begin
                     cnt_q <= cnt_q + DIV_W'(1);
                  end
               end
               STOP: begin
                  if (cnt_q == full_m1) begin
                     if (!rx_sync) begin
                        frame_err_o <= 1'b1;
                     end else if (full_i) begin
                        overrun_o <= 1'b1;
                     end else begin
                        wr_en_o <= 1'b1;
                        data_o  <= shift_q;
                     end
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     busy_o  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + DIV_W'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_o  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomised frames against a frame-level reference model.
module tb_uart_rx_core;

   localparam int SYNC_STAGES = 2;
   localparam int DIV_W       = 16;

   localparam logic [7:0] EV_WR = 8'h01;
   localparam logic [7:0] EV_FE = 8'h02;
   localparam logic [7:0] EV_OV = 8'h03;

   logic             clk = 1'b0;
   logic             rst;
   logic             rxEn;
   logic [DIV_W-1:0] cpb;
   logic             rx;
   logic             full;
   logic [7:0]       dataOut;
   logic             wrEn;
   logic             frameErr;
   logic             overrun;
   logic             busy;

   int               checks   = 0;
   int               failures = 0;
   logic [15:0]      expQ[$];
   logic [15:0]      obsQ[$];
   logic [7:0]       lastGood;
   int               latencyEdges;

   // Free-running system clock
   always #5 clk = ~clk;

   uart_rx_core #(
      .SYNC_STAGES(SYNC_STAGES),
      .DIV_W      (DIV_W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rx_en_i       (rxEn),
      .clks_per_bit_i(cpb),
      .rx_i          (rx),
      .full_i        (full),
      .data_o        (dataOut),
      .wr_en_o       (wrEn),
      .frame_err_o   (frameErr),
      .overrun_o     (overrun),
      .busy_o        (busy)
   );

   // Record every output pulse together with the byte shown on data_o at that moment
   always @(negedge clk) begin
      if (!rst) begin
         if (wrEn)     obsQ.push_back({EV_WR, dataOut});
         if (frameErr) obsQ.push_back({EV_FE, dataOut});
         if (overrun)  obsQ.push_back({EV_OV, dataOut});
      end
   end

   // Abort rather than hang if something stalls the sequence
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model: what one complete 8N1 frame must produce downstream
   task automatic expectFrame(input logic [7:0] b, input bit stopBit, input bit fullFlag);
      if (!stopBit) begin
         expQ.push_back({EV_FE, lastGood});
      end else if (fullFlag) begin
         expQ.push_back({EV_OV, lastGood});
      end else begin
         expQ.push_back({EV_WR, b});
         lastGood = b;
      end
   endtask

   task automatic sendBit(input bit b, input int n);
      rx = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input bit fullFlag,
                                input logic [DIV_W-1:0] cpbVal);
      int n;
      n   = (cpbVal < 4) ? 4 : int'(cpbVal);
      cpb = cpbVal;
      sendBit(1'b0, n);
      full = fullFlag;
      cpb  = DIV_W'($urandom);
      for (int i = 0; i < 8; i++) sendBit(b[i], n);
      sendBit(stopBit, n);
      expectFrame(b, stopBit, fullFlag);
   endtask

   task automatic compareEvents(input string tag);
      checkOutput({tag, "_count"}, obsQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
         checkOutput(tag, obsQ[i], expQ[i]);
      obsQ.delete();
      expQ.delete();
   endtask

   // Main sequence: reset, directed scenarios, then randomised frames
   initial begin
      rst      = 1'b1;
      rx       = 1'b1;
      rxEn     = 1'b0;
      full     = 1'b0;
      cpb      = DIV_W'(16);
      lastGood = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_data", dataOut, 8'h00);
      checkOutput("reset_wr", wrEn, 1'b0);
      checkOutput("reset_fe", frameErr, 1'b0);
      checkOutput("reset_ov", overrun, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      rst  = 1'b0;
      rxEn = 1'b1;
      idleCycles(5);

      $display("[TB] T1 basic frame and latency");
      fork
         applyStimulus(8'hA5, 1'b1, 1'b0, DIV_W'(16));
         begin
            latencyEdges = 0;
            while (latencyEdges < 400) begin
               @(posedge clk);
               latencyEdges++;
               @(negedge clk);
               if (wrEn) break;
            end
         end
      join
      checkOutput("t1_latency", latencyEdges - 1, SYNC_STAGES + 16 / 2 + 9 * 16);
      idleCycles(20);
      compareEvents("t1");
      checkOutput("t1_data_held", dataOut, 8'hA5);

      $display("[TB] T2 start glitch rejection");
      cpb = DIV_W'(16);
      rx  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idleCycles(40);
      checkOutput("t2_busy", busy, 1'b0);
      compareEvents("t2");

      $display("[TB] T3 framing error and held-low line");
      applyStimulus(8'h3C, 1'b0, 1'b0, DIV_W'(16));
      repeat (50) @(posedge clk);
      #1;
      checkOutput("t3_busy_low", busy, 1'b0);
      idleCycles(20);
      applyStimulus(8'h11, 1'b1, 1'b0, DIV_W'(16));
      idleCycles(20);
      compareEvents("t3");

      $display("[TB] T4 overrun then recovery");
      applyStimulus(8'h7E, 1'b1, 1'b1, DIV_W'(8));
      idleCycles(10);
      applyStimulus(8'h81, 1'b1, 1'b0, DIV_W'(8));
      idleCycles(10);
      compareEvents("t4");

      $display("[TB] T5 clamped divisor back-to-back");
      applyStimulus(8'h00, 1'b1, 1'b0, DIV_W'(2));
      applyStimulus(8'hFF, 1'b1, 1'b0, DIV_W'(2));
      applyStimulus(8'h55, 1'b1, 1'b0, DIV_W'(2));
      applyStimulus(8'hAA, 1'b1, 1'b0, DIV_W'(2));
      idleCycles(10);
      compareEvents("t5");

      $display("[TB] T6 reset and disable aborts");
      cpb = DIV_W'(16);
      sendBit(1'b0, 16);
      sendBit(1'b1, 16);
      sendBit(1'b0, 16);
      sendBit(1'b0, 16);
      checkOutput("t6_busy_mid", busy, 1'b1);
      rst = 1'b1;
      rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t6_rst_data", dataOut, 8'h00);
      checkOutput("t6_rst_busy", busy, 1'b0);
      lastGood = 8'h00;
      rst = 1'b0;
      idleCycles(20);
      sendBit(1'b0, 16);
      sendBit(1'b0, 16);
      sendBit(1'b1, 16);
      sendBit(1'b1, 16);
      rxEn = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("t6_dis_busy", busy, 1'b0);
      sendBit(1'b0, 15);
      sendBit(1'b0, 16);
      sendBit(1'b1, 16);
      sendBit(1'b1, 16);
      sendBit(1'b0, 16);
      sendBit(1'b1, 16);
      idleCycles(20);
      rxEn = 1'b1;
      idleCycles(10);
      compareEvents("t6_abort");
      applyStimulus(8'h5A, 1'b1, 1'b0, DIV_W'(16));
      idleCycles(20);
      compareEvents("t6_recover");

      $display("[TB] Randomised frames");
      for (int f = 0; f < 40; f++) begin
         logic [DIV_W-1:0] cpbVal;
         logic [7:0]       b;
         bit               stopBit;
         bit               fullFlag;
         int               n;
         cpbVal   = DIV_W'($urandom_range(0, 12));
         n        = (cpbVal < 4) ? 4 : int'(cpbVal);
         b        = 8'($urandom);
         stopBit  = ($urandom_range(0, 5) != 0);
         fullFlag = ($urandom_range(0, 3) == 0);
         applyStimulus(b, stopBit, fullFlag, cpbVal);
         if (!stopBit)
            idleCycles(n + int'($urandom_range(0, n)));
         else if ($urandom_range(0, 1) == 1)
            idleCycles(int'($urandom_range(1, 2 * n)));
      end
      idleCycles(40);
      compareEvents("rand");
      checkOutput("rand_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
